// File: rtl/fetch_defs.sv
// Shared constants for the instruction fetch stage: FSM encodings, reset PC and the NOP word.
package fetch_defs;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetched {pc, instr} entries; flush wins over pop and push.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through cnt_q.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads to instruction memory,
// buffers in-order responses and drains stale responses after a redirect.
module fetch_unit
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] fifo_cnt, fifo_cnt_d;
  logic [CW:0]   credit_sum;
  logic          held, push, pop, fifo_empty, fifo_full;
  logic [31:0]   rsp_pc;
  logic [63:0]   head;

  assign held = req_q && !imem_gnt;
  assign push = imem_rvalid && (state_q == ST_RUN) && !redirect_en;
  assign pop  = instr_valid && instr_ready;

  // In RUN all outstanding requests are consecutive words ending just below fetch_pc.
  assign rsp_pc = fetch_pc_q - 32'({out_cnt_q, 2'b00});

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_q && imem_gnt) out_cnt_d = out_cnt_d + CW'(1);
    if (imem_rvalid && (out_cnt_q != '0)) out_cnt_d = out_cnt_d - CW'(1);

    fifo_cnt_d = redirect_en ? '0 : fifo_cnt + CW'(push) - CW'(pop);

    // A grant in DRAIN belongs to a stale request and must not move the restart address.
    fetch_pc_d = fetch_pc_q;
    if ((state_q == ST_RUN) && req_q && imem_gnt) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_en) fetch_pc_d = align_pc(redirect_pc);

    state_d = state_q;
    if (redirect_en || (state_q == ST_DRAIN)) begin
      state_d = ((out_cnt_d != '0) || held) ? ST_DRAIN : ST_RUN;
    end

    credit_sum = {1'b0, fifo_cnt_d} + {1'b0, out_cnt_d};
    req_d      = held;
    addr_d     = addr_q;
    if (!held && (state_d == ST_RUN) && (credit_sum < (CW + 1)'(DEPTH))) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({rsp_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_en),
    .head_data (head),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = !fifo_empty && (state_q == ST_RUN);
  assign instr       = instr_valid ? head[31:0] : '0;
  assign instr_pc    = instr_valid ? head[63:32] : '0;

  assert property (@(posedge clock) disable iff (!reset_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-configurable memory model, in-order delivery
// scoreboard, a per-cycle vector table and hand sequences for stall, drain, wrap and reset.
module tb_fetch_unit;
  import fetch_defs::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  fetch_unit #(
    .RESET_PC (DEFAULT_RESET_PC),
    .DEPTH    (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clock = ~clock;

  int passes = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return NOP_WORD ^ {a[23:0], 8'h00};
  endfunction

  // Memory model: handshakes recorded at the edge, responses driven mid-cycle.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] gnt_log[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned gnt_count = 0;
  logic        gnt_en = 1'b1;

  always @(posedge clock) begin
    if (!reset_n) begin
      pend_q.delete();
      gnt_count <= 0;
    end else begin
      if (imem_rvalid && (pend_q.size() != 0)) void'(pend_q.pop_front());
      if (imem_req && imem_gnt) begin
        pend_q.push_back('{imem_addr, cyc + lat});
        gnt_log.push_back(imem_addr);
        gnt_count <= gnt_count + 1;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    #2;
    imem_gnt = reset_n && imem_req && gnt_en;
    if (reset_n && (pend_q.size() != 0) && (pend_q[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Delivery scoreboard: every consumed word must be the next expected PC with its mem word.
  logic [31:0] exp_pc = DEFAULT_RESET_PC;
  int unsigned cons_count = 0;

  always @(negedge clock) begin
    #2;
    if (reset_n && !redirect_en && instr_valid && instr_ready) begin
      check("deliver_pc", instr_pc, exp_pc);
      check("deliver_instr", instr, memword(exp_pc));
      exp_pc = exp_pc + 32'd4;
      cons_count++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset_n     = 1'b0;
    redirect_en = 1'b0;
    gnt_en      = 1'b1;
    lat         = 1;
    instr_ready = ready;
    exp_pc      = DEFAULT_RESET_PC;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    exp_pc      = {target[31:2], 2'b00};
    tick();
    redirect_en = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required self-finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c0;

    // Cycle k = period after the k-th edge following reset release; lat=1, always-grant.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    #1;
    reset_n = 1'b0;
    tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    tick();
    reset_n     = 1'b1;
    instr_ready = 1'b1;

    // Streaming, backpressure and resume.
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("tbl%0d_req", i), imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
        check($sformatf("tbl%0d_instr", i), instr, memword(tbl[i].exp_pc));
      end else begin
        check($sformatf("tbl%0d_instr0", i), instr, 32'h0);
      end
      instr_ready = tbl[i].ready;
      gnt_en      = tbl[i].gnt;
    end
    repeat (4) tick();

    // Consumer stalled from reset: exactly DEPTH grants, then idle.
    do_reset(1'b0);
    repeat (8) tick();
    check("full_gnts", gnt_count, 4);
    check("full_req", imem_req, 1'b0);
    check("full_head", instr_pc, 32'h0);

    // Redirect with nothing outstanding, into the address wrap.
    gnt_log.delete();
    c0 = cons_count;
    do_redirect(32'hFFFF_FFF8);
    check("idle_redir_valid", instr_valid, 1'b0);
    check("idle_redir_req", imem_req, 1'b1);
    check("idle_redir_addr", imem_addr, 32'hFFFF_FFF8);
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && (cons_count < c0 + 3); i++) tick();
    check("wrap_cons", 32'(cons_count >= c0 + 3), 32'd1);
    check("wrap_nreq", 32'(gnt_log.size() >= 3), 32'd1);
    if (gnt_log.size() >= 3) begin
      check("wrap_a0", gnt_log[0], 32'hFFFF_FFF8);
      check("wrap_a1", gnt_log[1], 32'hFFFF_FFFC);
      check("wrap_a2", gnt_log[2], 32'h0000_0000);
    end

    // Grant stalled for five cycles.
    do_reset(1'b1);
    gnt_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("stall%0d_req", i), imem_req, 1'b1);
      check($sformatf("stall%0d_addr", i), imem_addr, 32'h0);
    end
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    check("stall_gnts", gnt_count, 1);
    check("stall_next_addr", imem_addr, 32'h4);
    tick();
    check("stall_hold_gnts", gnt_count, 1);
    check("stall_hold_req", imem_req, 1'b1);
    check("stall_hold_addr", imem_addr, 32'h4);
    gnt_en = 1'b1;
    repeat (6) tick();

    // Redirect with two responses in flight, 3-cycle memory.
    do_reset(1'b1);
    lat = 3;
    tick();
    check("drn_addr0", imem_addr, 32'h0);
    tick();
    check("drn_addr1", imem_addr, 32'h4);
    do_redirect(32'h0000_0103);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drn%0d_req", i), imem_req, 1'b0);
      check($sformatf("drn%0d_valid", i), instr_valid, 1'b0);
      tick();
    end
    check("drn_new_req", imem_req, 1'b1);
    check("drn_new_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    check("drn_first_valid", instr_valid, 1'b1);
    check("drn_first_pc", instr_pc, 32'h0000_0100);
    repeat (4) tick();

    // Reset pulsed mid-stream with three buffered entries.
    do_reset(1'b0);
    repeat (5) tick();
    check("mrst_pre_valid", instr_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mrst_valid", instr_valid, 1'b0);
    check("mrst_req", imem_req, 1'b0);
    check("mrst_pc", instr_pc, 32'h0);
    exp_pc = DEFAULT_RESET_PC;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("mrst_restart_req", imem_req, 1'b1);
    check("mrst_restart_addr", imem_addr, DEFAULT_RESET_PC);
    check("mrst_out_cnt", 32'(dut.out_cnt_q), 32'h0);
    check("mrst_restart_valid", instr_valid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the core's decode/execute datapath. Owns the fetch PC and issues word reads to a variable-latency instruction memory over a request/grant/response handshake. Buffers returned instructions, tagged with their PC, in a small in-order FIFO. Presents them to the core through a valid/ready interface and flushes on a redirect (taken branch or jump) from the core.

## Interface
Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, 2..16

Ports:
- clock  in  1  rising-edge clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- redirect_en  in  1  core requests a fetch restart this cycle
- redirect_pc  in  32  restart address; bits [1:0] ignored and forced to 0
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned request address
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid; responses return in request order
- imem_rdata  in  32  returned instruction word
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr  out  32  instruction word; 0 when instr_valid=0
- instr_pc  out  32  address of instr; 0 when instr_valid=0
- instr_ready  in  1  core consumes the instruction this cycle

## Operation
- State machine with states RUN and DRAIN. Reset enters RUN.
- Registers:
  - fetch_pc: next address to request.
  - out_cnt: requests granted with no response yet.
  - FIFO of {pc, instr}, with count fifo_cnt.
- Issue: imem_req=1 in RUN when fifo_cnt + out_cnt + (any request already granted this cycle) < DEPTH. imem_addr=fetch_pc.
- Request hold: once imem_req is asserted it stays asserted, with imem_addr unchanged, until imem_gnt=1. This holds even across a redirect or a DRAIN entry.
- On grant: fetch_pc += 4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0). out_cnt increments.
- On imem_rvalid: out_cnt decrements. In RUN, {pc of the oldest outstanding request, imem_rdata} is pushed into the FIFO. The PC of each outstanding request is tracked in a small PC queue or recomputed from the FIFO tail PC.
- Grant and rvalid in the same cycle belong to different requests; out_cnt is unchanged.
- Pop: FIFO head is removed when instr_valid && instr_ready. instr_valid = (fifo_cnt != 0) && state==RUN.
- Redirect (redirect_en=1, any state):
  - FIFO flushed; a simultaneous pop is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - If out_cnt (after this cycle's grant and response updates) is nonzero, or a request is pending ungranted: go to DRAIN. Otherwise stay in RUN.
- DRAIN:
  - No new requests are started.
  - A held, ungranted request completes its handshake; the grant counts into out_cnt.
  - All responses are discarded.
  - Exit to RUN when out_cnt==0 and no request is pending.
  - A further redirect in DRAIN overwrites fetch_pc and remains in DRAIN.
- FIFO full: the credit rule guarantees no overflow. A response arriving with the FIFO full is a design error and is asserted on in simulation.

## Timing
- Reset values (asynchronous): state=RUN, fetch_pc=RESET_PC, out_cnt=0, fifo_cnt=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- First imem_req=1, with imem_addr=RESET_PC, appears in the first clock cycle after reset_n deasserts. imem_req is registered.
- Memory latency: rvalid for a request is no earlier than the cycle after its grant.
- Response to consumer: rvalid at cycle N gives instr_valid=1 at N+1 (registered FIFO write). With zero-latency consumption and 1-cycle memory, throughput is one instruction per cycle.
- Redirect at cycle t with nothing outstanding: imem_req=1 with imem_addr=redirect_pc at t+1. The old instr_valid is deasserted at t+1.
- Redirect with k outstanding responses: the new request issues the cycle after the last discarded rvalid.
- Reset asserted mid-operation: all state clears immediately. Responses to pre-reset requests are the memory's responsibility and are not tracked.

## Structure
- Shared constants header/package fetch_defs:
  - state encodings (ST_RUN, ST_DRAIN)
  - NOP word 32'h00000013 for bench use
  - default RESET_PC
- One sub-module: fetch_fifo, a synchronous FIFO with parameterised DEPTH, 64-bit entries {pc, instr}, push/pop/flush inputs, and count/empty/full outputs. The flush input has priority over pop.

## Test plan
- Reset release, 1-cycle memory, instr_ready=1 -> imem_addr 0, 4, 8, … on consecutive cycles. instr_valid from cycle 3 with instr_pc 0, 4, 8 and instr equal to the mem words.
- instr_ready=0, memory always grants -> exactly DEPTH=4 grants, then imem_req stays 0. Raising instr_ready resumes issue the cycle after the first pop. No word is lost.
- Grant stalled 5 cycles -> imem_req and imem_addr stay stable all 5 cycles. Exactly one grant is counted.
- Redirect to 32'h00000103 with 2 responses in flight (3-cycle latency) -> both responses dropped, instr_valid=0 during DRAIN. The next request carries address 32'h00000100, and the first delivered instr_pc is 32'h00000100.
- fetch_pc at 32'hFFFFFFF8 -> requests FFFFFFF8, FFFFFFFC, 00000000. instr_pc wraps identically.
- reset_n pulsed low mid-stream with FIFO holding 3 entries -> instr_valid=0 immediately. After release, fetch restarts at RESET_PC with out_cnt=0.
